// File: rtl/bls_pkg.sv
// Shared constants and types for the borrow-lookahead adder/subtractor family.
package bls_pkg;

   localparam int unsigned BLS_BLK = 4;

   typedef enum logic {
      OP_SUB = 1'b0,
      OP_ADD = 1'b1
   } bls_op_e;

   function automatic int unsigned bls_stages(input int unsigned width);
      return width / BLS_BLK;
   endfunction

endpackage

// File: rtl/bls_blk4.sv
// Combinational 4-bit lookahead block; the same g/p recurrence serves
// borrow (sub) and carry (add), only the generate/propagate terms change.
module bls_blk4
   import bls_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       op,
   input  logic       bi,
   output logic [3:0] d,
   output logic       bo
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   always_comb begin
      if (op == OP_ADD) begin
         g = a & b;
         p = a | b;
      end else begin
         g = ~a & b;
         p = ~a | b;
      end
      c[0] = bi;
      c[1] = g[0] | (p[0] & bi);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
      bo   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & bi);
      d    = a ^ b ^ c;
   end

endmodule

// File: rtl/bls_pipe_addsub.sv
// Pipelined borrow-lookahead adder/subtractor, one 4-bit block per stage.
// Define BLS_OVF_EN to add the registered signed-overflow output ovf.
module bls_pipe_addsub
   import bls_pkg::*;
#(
   parameter int unsigned WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             bout
`ifdef BLS_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NS = bls_stages(WIDTH);

   logic adv;

   // Global stall: the whole pipe freezes while the output beat is refused.
   assign in_ready = !(out_valid && !out_ready);
   assign adv      = in_ready;

   for (genvar k = 0; k < NS; k++) begin : stg
      // a_in/b_in hold only the operand bits not yet consumed by earlier stages
      localparam int unsigned RW = WIDTH - BLS_BLK * k;
      localparam int unsigned DW = BLS_BLK * (k + 1);

      logic [RW-1:0] a_in;
      logic [RW-1:0] b_in;
      logic          op_in;
      logic          bi_in;
      logic          v_in;
      logic [3:0]    d_n;
      logic          bo_n;
      logic [DW-1:0] d_nx;
      logic [DW-1:0] d_q;
      logic          c_q;
      logic          op_q;
      logic          v_q;

      if (k == 0) begin : head
         assign a_in  = A;
         assign b_in  = B;
         assign op_in = op;
         assign bi_in = bin;
         assign v_in  = in_valid;
         assign d_nx  = d_n;
      end else begin : link
         always_ff @(posedge clk) begin
            if (rst) begin
               a_in <= '0;
               b_in <= '0;
            end else if (adv) begin
               a_in <= stg[k-1].a_in[RW+BLS_BLK-1:BLS_BLK];
               b_in <= stg[k-1].b_in[RW+BLS_BLK-1:BLS_BLK];
            end
         end
         assign op_in = stg[k-1].op_q;
         assign bi_in = stg[k-1].c_q;
         assign v_in  = stg[k-1].v_q;
         assign d_nx  = {d_n, stg[k-1].d_q};
      end

      bls_blk4 u_blk (
         .a  (a_in[3:0]),
         .b  (b_in[3:0]),
         .op (op_in),
         .bi (bi_in),
         .d  (d_n),
         .bo (bo_n)
      );

      always_ff @(posedge clk) begin
         if (rst) begin
            d_q  <= '0;
            c_q  <= 1'b0;
            op_q <= 1'b0;
            v_q  <= 1'b0;
         end else if (adv) begin
            d_q  <= d_nx;
            c_q  <= bo_n;
            op_q <= op_in;
            v_q  <= v_in;
         end
      end
   end

   assign out_valid = stg[NS-1].v_q;
   assign D         = stg[NS-1].d_q;
   assign bout      = stg[NS-1].c_q;

`ifdef BLS_OVF_EN
   logic sa;
   logic sb;
   logic sd;
   logic ovf_n;

   // Operand sign bits arrive with the top nibble through the skew chain.
   assign sa = stg[NS-1].a_in[3];
   assign sb = stg[NS-1].b_in[3];
   assign sd = stg[NS-1].d_n[3];

   always_comb begin
      if (stg[NS-1].op_in == OP_ADD) ovf_n = (sa == sb) && (sd != sa);
      else                           ovf_n = (sa != sb) && (sd != sa);
   end

   always_ff @(posedge clk) begin
      if (rst)      ovf <= 1'b0;
      else if (adv) ovf <= ovf_n;
   end
`endif

endmodule

// File: tb/tb_bls_pipe_addsub.sv
// Scoreboard bench for bls_pipe_addsub (WIDTH=16); ovf checks follow BLS_OVF_EN.
module tb_bls_pipe_addsub;

   localparam int unsigned W  = 16;
   localparam int unsigned NS = W / 4;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
      int unsigned  acc;
      bit           lat;
      bit           seq;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         op;
   logic [W-1:0] opa;
   logic [W-1:0] opb;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] res;
   logic         bout;
   logic         ovf;

   int unsigned  nchk = 0;
   int unsigned  nerr = 0;
   int unsigned  cyc = 0;
   int unsigned  last_pop = 0;
   exp_t         sbq[$];
   exp_t         mon_e;
   logic [W-1:0] hold_d;
   logic         hold_b;
   logic         hold_o;

   bls_pipe_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .A         (opa),
      .B         (opb),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (res),
      .bout      (bout)
`ifdef BLS_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

`ifndef BLS_OVF_EN
   assign ovf = 1'b0;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic o, input logic bi);
      exp_t        m;
      logic [W:0]  f;
      if (o) f = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, bi};
      else   f = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
      m.d   = f[W-1:0];
      m.bo  = f[W];
      m.ov  = o ? ((a[W-1] == b[W-1]) && (f[W-1] != a[W-1]))
                : ((a[W-1] != b[W-1]) && (f[W-1] != a[W-1]));
      m.acc = 0;
      m.lat = 1'b0;
      m.seq = 1'b0;
      return m;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                       input logic bi, input bit lat, input bit seq);
      exp_t e;
      in_valid = 1'b1;
      opa      = a;
      opb      = b;
      op       = o;
      bin      = bi;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      chk("accept", {31'b0, in_ready}, 32'd1);
      if (in_ready) begin
         e     = model(a, b, o, bi);
         e.acc = cyc;
         e.lat = lat;
         e.seq = seq;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 64; n++) begin
         if (sbq.size() == 0) break;
         @(negedge clk);
      end
      chk("drain", sbq.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
      end else if (out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            chk("spurious_out", {31'b0, out_valid}, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk("D", {16'b0, res}, {16'b0, mon_e.d});
            chk("bout", {31'b0, bout}, {31'b0, mon_e.bo});
`ifdef BLS_OVF_EN
            chk("ovf", {31'b0, ovf}, {31'b0, mon_e.ov});
`endif
            if (mon_e.lat) chk("latency", cyc - mon_e.acc, NS);
            if (mon_e.seq) chk("bubble", cyc - last_pop, 32'd1);
            last_pop = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 1'b0;
      opa       = '0;
      opb       = '0;
      bin       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_D", {16'b0, res}, 32'd0);
      chk("rst_bout", {31'b0, bout}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      send(16'h1234, 16'h0235, 1'b0, 1'b0, 1'b1, 1'b0);
      drain();

      send(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      send(16'h00FF, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
      send(16'h1000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      send(16'h0FFF, 16'h0FFF, 1'b0, 1'b1, 1'b0, 1'b0);
      drain();

      for (int i = 0; i < 8; i++)
         send(16'($urandom), 16'($urandom), 1'(i % 2), 1'($urandom_range(1)), 1'b0, i > 0);
      drain();

      for (int i = 0; i < 6; i++)
         send(16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b0);
      out_ready = 1'b0;
      @(negedge clk);
      hold_d = res;
      hold_b = bout;
      hold_o = ovf;
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
         chk("stall_D", {16'b0, res}, {16'b0, hold_d});
         chk("stall_bout", {31'b0, bout}, {31'b0, hold_b});
         chk("stall_ovf", {31'b0, ovf}, {31'b0, hold_o});
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0);
      send(16'h5A5A, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b0);
      drain();

      for (int i = 0; i < 3; i++)
         send(16'h1111 * 16'(i + 1), 16'h0101, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_D", {16'b0, res}, 32'd0);
      chk("flush_bout", {31'b0, bout}, 32'd0);
      chk("flush_ovf", {31'b0, ovf}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("stale_beat", {31'b0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      send(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      send(16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      send(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/bls_pipe_addsub.md
# bls_pipe_addsub

Parametrised, pipelined borrow-lookahead adder/subtractor. Operands are processed in 4-bit lookahead blocks, one block per pipeline stage, so one new operation is accepted per clock with latency WIDTH/4. It is the multi-word successor of the team's 4-bit combinational BLS. It also adds an add mode, a valid/ready handshake with backpressure, and an optional signed-overflow flag. It sits between an operand source (register file or test driver) and a result consumer.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of 4 and ≥ 4.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block can accept a beat this cycle.
- `op` input 1: 0 = subtract (A − B − bin); 1 = add (A + B + bin, where bin acts as carry-in).
- `A` input WIDTH: minuend / addend.
- `B` input WIDTH: subtrahend / addend.
- `bin` input 1: borrow-in (sub) or carry-in (add).
- `out_valid` output 1: result beat valid.
- `out_ready` input 1: consumer accepts the result this cycle.
- `D` output WIDTH: difference / sum.
- `bout` output 1: borrow-out (sub) or carry-out (add) of the MSB.
- `ovf` output 1: signed overflow; present only with `BLS_OVF_EN`.

## Operation
- Stages: NS = WIDTH/4. Stage k computes bits [4k+3:4k] from the registered operands and the borrow/carry registered by stage k−1. Stage 0 uses `bin`.
- Per-block sub logic: g = ~A&B, p = ~A|B, b(i+1) = g | p&b(i), D = A^B^b(i).
- Per-block add logic: g = A&B, p = A|B, same recurrences.
- Each stage registers:
  - its D nibble;
  - block borrow/carry out;
  - `op`;
  - a valid bit;
  - the still-unused upper A/B nibbles (skew). Lower result nibbles travel alongside (deskew).
- Handshake:
  - Accept when `in_valid && in_ready`.
  - Output transfer when `out_valid && out_ready`.
  - `in_ready = !(out_valid && !out_ready)`.
  - The whole pipeline advances only when `in_ready` is high (global stall). Bubbles are not compressed.
- Stall: all stage registers hold. D, bout and ovf stay stable while `out_valid && !out_ready`.
- A cycle with `in_ready=1` and `in_valid=0` inserts a bubble: stage-0 valid=0. Data registers may update, but are don't-care when their valid is 0.
- `op` is captured per beat. Add and sub beats may interleave freely.
- Arithmetic is modulo 2^WIDTH. `bout` is the final block borrow/carry.
- Reset: all valid bits 0, `out_valid`=0, D=0, bout=0, ovf=0. `in_ready`=1 in the cycle after reset.
- Reset mid-operation: every in-flight beat is discarded and never emerges.

## Timing
- Latency NS cycles: a beat accepted at edge t appears with `out_valid`=1 after edge t+NS−1 (WIDTH=16 → 4 cycles), assuming no stall.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Stall cycles add directly to latency. No beat is lost or duplicated.
- Combinational path per stage: one 4-bit lookahead block only. No through-path from `in_valid` to `out_valid`.
- `in_ready` depends combinationally on `out_ready`. This is the only comb path from input to output.

## Configuration
- `BLS_OVF_EN` defined: `ovf` port exists and is registered with the result.
  - Sub: A and B signs differ and the D sign differs from A.
  - Add: A and B signs are equal and the D sign differs.
  - Sign bits travel in the skew pipeline.
- `BLS_OVF_EN` undefined: `ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `bls_pkg`:
  - constant `BLS_BLK` = 4;
  - enum `bls_op_e` {OP_SUB=0, OP_ADD=1};
  - function for the stage count (WIDTH/BLS_BLK).
- Sub-module `bls_blk4`: combinational 4-bit lookahead block with inputs a, b, op, bi and outputs d, bo. Instantiate it NS times via generate.
- Top module holds the stage registers, skew/deskew and the handshake.

## Test plan
- WIDTH=16, sub 0x1234 − 0x0235, bin=0 → D=0x0FFF, bout=0, out_valid exactly 4 cycles after accept.
- Sub 0x0000 − 0x0001, bin=0 → D=0xFFFF, bout=1. Add 0xFFFF + 0x0001, bin=0 → D=0x0000, bout=1.
- Back-to-back 8 beats alternating add/sub with `out_ready`=1 → 8 consecutive results in order, matching the model, with no bubbles.
- Hold `out_ready`=0 for 3 cycles with the pipeline full → `in_ready`=0, D/bout stable, no beat lost. On release, results resume in order.
- `rst` asserted for 1 cycle with 3 beats in flight → out_valid=0, D=0, bout=0 next cycle; no stale beat ever emerges.
- With `BLS_OVF_EN`: sub 0x8000 − 0x0001 → D=0x7FFF, ovf=1. Add 0x7FFF + 0x0001 → D=0x8000, ovf=1. Add 0x0001 + 0x0001 → ovf=0.
